// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register chain with synchronous flush
// and an occupancy count; empty slots collapse so upstream keeps moving.
module reg_pipe #(
    parameter int              WIDTH     = 16,
    parameter int              DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d    [DEPTH];
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [DEPTH-1:0] up_v;
    logic [DEPTH-1:0] adv;
    logic             in_xfer;
    logic             out_xfer;

    // A stage may advance when any slot at or below it is free.
    always_comb begin
        logic a;
        a = out_ready | ~v[DEPTH-1];
        adv = '0;
        adv[DEPTH-1] = a;
        for (int i = DEPTH-2; i >= 0; i--) begin
            a = a | ~v[i];
            adv[i] = a;
        end
    end

    always_comb begin
        up_v    = '0;
        up_v[0] = in_xfer;
        up_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = d[i-1];
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = v[DEPTH-1] & out_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v     <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RESET_VAL;
            end
        end else if (flush) begin
            v     <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v[i] <= up_v[i];
                    if (up_v[i]) begin
                        d[i] <= up_d[i];
                    end
                end
            end
            case ({in_xfer, out_xfer})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed and random checks of reg_pipe against a slot/queue
// model kept in the bench.
module tb_reg_pipe;
    localparam int          W  = 16;
    localparam int          D  = 3;
    localparam logic [15:0] RV = 16'hDEAD;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    int checks = 0;
    int errors = 0;

    reg_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: slots (word positions) plus an in-order scoreboard of words held.
    bit           mv [D];
    logic [W-1:0] md [D];
    logic [W-1:0] sb [$];
    logic [W-1:0] got [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit iv, input logic [15:0] id,
                         input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int occ;
        bit in_acc;
        bit out_acc;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                foreach (mv[i]) mv[i] = 1'b0;
                sb.delete();
            end else begin
                occ     = sb.size();
                in_acc  = in_valid && !flush && (occ < D || out_ready);
                out_acc = mv[D-1] && out_ready;
                if (out_acc) begin
                    mv[D-1] = 1'b0;
                    void'(sb.pop_front());
                end
                if (flush) begin
                    foreach (mv[i]) mv[i] = 1'b0;
                    sb.delete();
                end else begin
                    for (int i = D-2; i >= 0; i--) begin
                        if (mv[i] && !mv[i+1]) begin
                            mv[i+1] = 1'b1;
                            md[i+1] = md[i];
                            mv[i]   = 1'b0;
                        end
                    end
                    if (in_acc) begin
                        mv[0] = 1'b1;
                        md[0] = in_data;
                        sb.push_back(in_data);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                check("out_valid", out_valid, mv[D-1]);
                check("count", count, sb.size());
                check("in_ready", in_ready,
                      !flush && (sb.size() < D || out_ready));
                if (mv[D-1]) begin
                    check("out_data", out_data, md[D-1]);
                    check("out_order", out_data, sb[0]);
                end
            end
        end
    end

    initial begin
        int nxt;
        rst = 1'b0;
        drive(0, 16'h0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, RV);
        check("rst_count", count, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // reset with two words in flight
        drive(1, 16'h0A01, 0, 0); tick();
        drive(1, 16'h0A02, 0, 0); tick();
        drive(0, 16'h0, 0, 0); tick(); tick();
        @(negedge clk);
        check("t1_count", count, 2);
        check("t1_data", out_data, 16'h0A01);
        #2 rst = 1'b0;
        #1;
        check("t1_rst_valid", out_valid, 0);
        check("t1_rst_data", out_data, RV);
        check("t1_rst_count", count, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // full-rate stream 0..99
        for (int c = 0; c <= 103; c++) begin
            drive(c < 100, 16'(c), 1, 0);
            @(negedge clk);
            if (c < 100) check("t2_in_ready", in_ready, 1);
            check("t2_out_valid", out_valid, (c >= 3 && c <= 102));
            if (c >= 3 && c <= 102) check("t2_data", out_data, 16'(c-3));
            check("t2_count", count, c <= 100 ? (c < 3 ? c : 3) : 103 - c);
            tick();
        end

        // backpressure, then full pipe with simultaneous in/out
        nxt = 0;
        got.delete();
        for (int c = 0; c < 20; c++) begin
            drive(nxt < 5, 16'(nxt), c >= 8, 0);
            @(negedge clk);
            if (c == 3) begin
                check("t3_in_ready_full", in_ready, 0);
                check("t3_count_full", count, 3);
                check("t3_head", out_data, 16'h0);
            end
            if (c == 7) check("t3_head_held", out_data, 16'h0);
            if (c == 8) begin
                check("t4_in_ready", in_ready, 1);
                check("t4_count_pre", count, 3);
            end
            if (c == 9) begin
                check("t4_count_post", count, 3);
                check("t4_head", out_data, 16'h1);
            end
            if (in_valid && in_ready) nxt++;
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
        end
        check("t3_accepted", nxt, 5);
        check("t3_got_n", got.size(), 5);
        foreach (got[i]) check("t3_order", got[i], i);

        // flush with two words held
        drive(1, 16'h0B01, 0, 0); tick();
        drive(1, 16'h0B02, 0, 0); tick();
        drive(1, 16'h5555, 0, 1);
        @(negedge clk);
        check("t5_count_pre", count, 2);
        check("t5_in_ready_flush", in_ready, 0);
        tick();
        drive(1, 16'h1234, 1, 0);
        @(negedge clk);
        check("t5_valid_post", out_valid, 0);
        check("t5_count_post", count, 0);
        tick();
        drive(0, 16'h0, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("t5_emerge_valid", out_valid, k == 3);
            if (k == 3) check("t5_emerge_data", out_data, 16'h1234);
            tick();
        end

        // random traffic with occasional flush
        for (int c = 0; c < 10000; c++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
            tick();
        end
        drive(0, 16'h0, 1, 0);
        repeat (5) tick();
        check("end_empty", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
